// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
//   Round-robin arbiter that shares the HEX5/HEX4 PIO slave between NREQ
//   requesters. The winner's byte is encoded as two active-low 7-segment
//   digits and written over the PIO Avalon-MM s1 port, which has no
//   waitrequest. A hold period after every write keeps the display from
//   flickering.
//
//   Optional feature (macro HEX_ARB_READBACK_EN): after each grant write,
//   a one-cycle CHECK read compares readdata[15:0] against the written
//   data. A mismatch sets the sticky err flag.
//
// Ports
//   clk, reset_n       clock, async active-low reset
//   req[NREQ]          level requests, held high until ack
//   req_value[8*NREQ]  requester i byte at [8i+7:8i]; hi nibble->HEX5
//   ack[NREQ]          one-cycle pulse in the granted write cycle
//   avm_*              PIO master side (address fixed at 0)
//   avm_readdata       used only for readback checking
//   busy               high in every state except IDLE
//   err                sticky readback mismatch (0 without readback)
module hex_display_arbiter #(
  parameter int NREQ        = 2,
  parameter int HOLD_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_value,
  output logic [NREQ-1:0]   ack,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              busy,
  output logic              err
);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
`ifdef HEX_ARB_READBACK_EN
    S_CHECK,
`endif
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     rr_q, rr_d, win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              cs_q, cs_d, wrn_q, wrn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [RW-1:0]     pick;
  logic [7:0]        pick_val;
  logic              unused_rd;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // First set request at or above rr_q, wrapping.
  always_comb begin
    logic found;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = RW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  assign pick_val = req_value[8*int'(pick) +: 8];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    cs_d    = 1'b0;
    wrn_d   = 1'b1;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_INIT: begin
        // PIO powers up at 0 (all segments lit); blank it.
        cs_d    = 1'b1;
        wrn_d   = 1'b0;
        wdata_d = 32'h0000_7F7F;
        cnt_d   = '0;
        state_d = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
      end
      S_IDLE: begin
        if (|req) begin
          win_d   = pick;
          ack_d   = NREQ'(1) << pick;
          cs_d    = 1'b1;
          wrn_d   = 1'b0;
          wdata_d = {16'h0, 1'b1, seg7(pick_val[7:4]), 1'b1, seg7(pick_val[3:0])};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        rr_d  = (win_q == RW'(NREQ - 1)) ? '0 : win_q + RW'(1);
        cnt_d = '0;
`ifdef HEX_ARB_READBACK_EN
        cs_d    = 1'b1;
        state_d = S_CHECK;
`else
        state_d = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
`endif
      end
`ifdef HEX_ARB_READBACK_EN
      S_CHECK: begin
        if (avm_readdata[15:0] != wdata_q[15:0]) err_d = 1'b1;
        state_d = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
      end
`endif
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = S_IDLE;
        else                                cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_INIT;
    endcase
  end

  // Bus outputs are registered so reset forces them idle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      rr_q    <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      cs_q    <= 1'b0;
      wrn_q   <= 1'b1;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      cs_q    <= cs_d;
      wrn_q   <= wrn_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign ack            = ack_q;
  assign avm_address    = 2'b00;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wrn_q;
  assign avm_writedata  = wdata_q;
  assign busy           = (state_q != S_IDLE);
`ifdef HEX_ARB_READBACK_EN
  assign err            = err_q;
`else
  assign err            = 1'b0;
`endif
  // Upper readdata bits never compared; readdata is unused without readback.
  assign unused_rd = ^{avm_readdata, err_q};

endmodule

// File: tb/tb_hex_display_arbiter.sv
module tb_hex_display_arbiter;
  localparam int NREQ = 2;
  localparam int HOLD = 4;
`ifdef HEX_ARB_READBACK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_value = '0;
  logic [NREQ-1:0]   ack;
  logic [1:0]        avm_address;
  logic              avm_chipselect, avm_write_n, busy, err;
  logic [31:0]       avm_writedata, avm_readdata, pio_q;
  logic              corrupt = 1'b0;
  int                n_chk = 0, n_fail = 0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  hex_display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_value(req_value), .ack(ack),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .busy(busy), .err(err));

  // PIO model: register written on cs & !write_n; optionally corrupts stored data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pio_q <= '0;
    else if (avm_chipselect && !avm_write_n) pio_q <= avm_writedata ^ (corrupt ? 32'h1 : 32'h0);
  end
  assign avm_readdata = pio_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc(input logic [7:0] v);
    return {16'h0, 1'b1, segtab[v[7:4]], 1'b1, segtab[v[3:0]]};
  endfunction

  // Ticks until a write strobe is seen; n = ticks taken, 0 on timeout.
  task automatic wait_write(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (avm_chipselect && !avm_write_n) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!busy) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic grant(input string tag, input logic [NREQ-1:0] exp_ack, input logic [31:0] exp_d);
    int n;
    wait_write(n);
    check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check({tag, "_data"}, avm_writedata, exp_d);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    check("rst_cs", 32'(avm_chipselect), 32'd0);
    check("rst_wrn", 32'(avm_write_n), 32'd1);
    check("rst_wdata", avm_writedata, 32'h0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);

    // 1: INIT blank write in cycle 1, then HOLD, then idle
    reset_n = 1'b1;
    tick();
    check("init_cs", 32'(avm_chipselect), 32'd1);
    check("init_wrn", 32'(avm_write_n), 32'd0);
    check("init_wdata", avm_writedata, 32'h0000_7F7F);
    check("init_ack", 32'(ack), 32'd0);
    tick();
    check("init_cs_off", 32'(avm_chipselect), 32'd0);
    wait_idle(n);
    check("init_hold_len", 32'(n), 32'(HOLD - 1));

    // 2: single request 0x3A, latency 1, hold length
    req = 2'b01; req_value = 16'h003A;
    wait_write(n);
    check("lat", 32'(n), 32'd1);
    check("t2_ack", 32'(ack), 32'd1);
    check("t2_data", avm_writedata, 32'h0000_B088);
    req = 2'b00;
    tick();
    check("t2_ack_pulse", 32'(ack), 32'd0);
    wait_idle(n);
    check("t2_hold_len", 32'(n), 32'(CHK + HOLD));

    // 3: both held; rr pointer is at 1 after serving requester 0
    req = 2'b11; req_value = 16'h5F12;
    grant("rr0", 2'b10, 32'h0000_928E);
    wait_write(n);
    check("rr_gap", 32'(n), 32'(2 + CHK + HOLD));
    check("rr1_ack", 32'(ack), 32'b01);
    check("rr1_data", avm_writedata, 32'h0000_F9A4);
    grant("rr2", 2'b10, 32'h0000_928E);
    grant("rr3", 2'b01, 32'h0000_F9A4);
    req = 2'b00;
    wait_idle(n);

    // 4: reset during WRITE aborts at once; INIT blank after release
    req = 2'b01; req_value = 16'h0077;
    wait_write(n);
    check("t4_ack_pre", 32'(ack), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_cs", 32'(avm_chipselect), 32'd0);
    check("abort_wrn", 32'(avm_write_n), 32'd1);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("reinit_cs", 32'(avm_chipselect), 32'd1);
    check("reinit_wdata", avm_writedata, 32'h0000_7F7F);
    wait_idle(n);

    // 5: encode sweep over every byte value
    for (int v = 0; v < 256; v++) begin
      req = 2'b01; req_value = {8'h00, 8'(v)};
      wait_write(n);
      check($sformatf("enc_%02h", v), avm_writedata, enc(8'(v)));
      req = 2'b00;
      wait_idle(n);
    end
    check("err_clean", 32'(err), 32'd0);

`ifdef HEX_ARB_READBACK_EN
    // 6: corrupted readback sets sticky err
    corrupt = 1'b1;
    req = 2'b01; req_value = 16'h0081;
    wait_write(n);
    req = 2'b00;
    wait_idle(n);
    check("err_set", 32'(err), 32'd1);
    corrupt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req = 2'b10; req_value = 16'h4200;
      wait_write(n);
      req = 2'b00;
      wait_idle(n);
      check("err_sticky", 32'(err), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
